// File: rtl/switchbank_fifo.sv
// Debounced switch-entry peripheral: each press of enter_key queues the synchronized
// switch value into a small FIFO that the CPU drains through the a0/ack polling port.
module switchbank_fifo #(
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  switches,
    input  logic        enter_key,
    input  logic        a0,
    input  logic        ack,
    output logic [15:0] data_out
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [1:0]        key_sync_reg;
    logic [7:0]        sw_meta_reg;
    logic [7:0]        sw_sync_reg;
    logic              k_s;

    logic              db_reg, db_next;
    logic              db_d_reg;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              ovf_reg, ovf_next;

    logic              push, pop, wr_en, ovf_set;
    logic              full, not_empty;
    logic [7:0]        entry [DEPTH];
    logic [7:0]        head;
    logic [7:0]        count_ext;

    assign k_s = key_sync_reg[1];

    // Synchronizers and debouncer state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_sync_reg <= '0;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            db_reg       <= 1'b0;
            db_d_reg     <= 1'b0;
            dcnt_reg     <= '0;
        end else begin
            key_sync_reg <= {key_sync_reg[0], enter_key};
            sw_meta_reg  <= switches;
            sw_sync_reg  <= sw_meta_reg;
            db_reg       <= db_next;
            db_d_reg     <= db_reg;
            dcnt_reg     <= dcnt_next;
        end
    end

    always_comb begin
        db_next   = db_reg;
        dcnt_next = dcnt_reg;
        if (k_s == db_reg) begin
            dcnt_next = '0;
        end else if (dcnt_reg == DCNT_MAX) begin
            db_next   = ~db_reg;
            dcnt_next = '0;
        end else begin
            dcnt_next = dcnt_reg + DCNT_W'(1);
        end
    end

    assign full      = (count_reg == CNT_FULL);
    assign not_empty = (count_reg != '0);
    assign push      = db_reg & ~db_d_reg;
    assign pop       = ack & ~a0 & not_empty;
    // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
    assign wr_en     = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (pop)   rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        if (ovf_set)        ovf_next = 1'b1;
        else if (ack && a0) ovf_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Storage is deliberately left unreset; count gates every read of it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [7:0] entry_reg;
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_reg == PTR_W'(gi))) entry_reg <= sw_sync_reg;
            end
            assign entry[gi] = entry_reg;
        end
    endgenerate

    assign head      = entry[rd_ptr_reg];
    assign count_ext = 8'(count_reg);

    always_comb begin
        data_out = 16'h0000;
        if (a0) begin
            data_out = {8'h00, count_ext[3:0], 1'b0, ovf_reg, full, not_empty};
        end else if (not_empty) begin
            data_out = {8'h00, head};
        end
    end

endmodule

// File: tb/tb_switchbank_fifo.sv
// Scoreboard bench for switchbank_fifo: stimulus queues expected read words,
// a monitor compares them whenever the CPU side issues an ack.
module tb_switchbank_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  switches;
    logic        enter_key;
    logic        a0;
    logic        ack;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    switchbank_fifo #(.DEPTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .switches  (switches),
        .enter_key (enter_key),
        .a0        (a0),
        .ack       (ack),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // Monitor: every ack cycle is one CPU read to be checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read got %h want <none>", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.data) begin
                        errors++;
                        $display("FAIL %s got %h want %h", e.name, data_out, e.data);
                    end else begin
                        $display("ok   %s a0=%0d data=%h", e.name, a0, data_out);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, input logic [15:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.data = exp;
        exp_q.push_back(e);
        a0  = sel;
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        a0  = 1'b0;
    endtask

    task automatic press(input logic [7:0] val);
        switches = val;
        idle(3);
        enter_key = 1'b1;
        idle(12);
        enter_key = 1'b0;
        idle(12);
    endtask

    initial begin
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        reset_n   = 1'b0;
        switches  = 8'h00;
        enter_key = 1'b0;
        a0        = 1'b0;
        ack       = 1'b0;
        idle(2);
        rd(1'b1, 16'h0000, "status_in_reset");
        rd(1'b0, 16'h0000, "data_in_reset");
        reset_n = 1'b1;
        idle(3);

        // Reset then idle
        rd(1'b1, 16'h0000, "idle_status");
        rd(1'b0, 16'h0000, "idle_data");
        idle(5);
        rd(1'b1, 16'h0000, "idle_status2");

        // Single held press: bit0 rises in the cycle after edge 7
        switches = 8'hA5;
        idle(3);
        enter_key = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            e.name = $sformatf("press_lat_c%0d", i);
            e.data = (i >= 7) ? 16'h0011 : 16'h0000;
            exp_q.push_back(e);
            a0  = 1'b1;
            ack = 1'b1;
            idle(1);
        end
        ack = 1'b0;
        a0  = 1'b0;
        enter_key = 1'b0;
        idle(12);
        rd(1'b1, 16'h0011, "one_entry_status");
        rd(1'b0, 16'h00A5, "one_entry_data");
        rd(1'b1, 16'h0000, "one_entry_drained");

        // Bounce shorter than the debounce window
        switches = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            enter_key = pat[i];
            idle(1);
        end
        enter_key = 1'b0;
        idle(12);
        rd(1'b1, 16'h0000, "bounce_status");
        rd(1'b0, 16'h0000, "bounce_data");

        // Fill, then a discarded fifth press coinciding with a status read
        press(8'h01);
        press(8'h02);
        press(8'h03);
        press(8'h04);
        rd(1'b1, 16'h0043, "full_status");
        switches = 8'h05;
        idle(3);
        enter_key = 1'b1;
        idle(6);
        rd(1'b1, 16'h0043, "ovf_set_wins_read");
        idle(8);
        enter_key = 1'b0;
        idle(12);
        rd(1'b1, 16'h0047, "ovf_status");
        rd(1'b1, 16'h0043, "ovf_cleared");
        rd(1'b0, 16'h0001, "drain_1");
        rd(1'b0, 16'h0002, "drain_2");
        rd(1'b0, 16'h0003, "drain_3");
        rd(1'b0, 16'h0004, "drain_4");
        rd(1'b1, 16'h0000, "drained_status");

        // Full FIFO: push and pop on the same edge
        press(8'h11);
        press(8'h22);
        press(8'h33);
        press(8'h44);
        switches = 8'h55;
        idle(3);
        enter_key = 1'b1;
        idle(6);
        rd(1'b0, 16'h0011, "pop_with_push");
        idle(8);
        enter_key = 1'b0;
        idle(12);
        rd(1'b1, 16'h0043, "full_no_ovf");
        rd(1'b0, 16'h0022, "wrap_1");
        rd(1'b0, 16'h0033, "wrap_2");
        rd(1'b0, 16'h0044, "wrap_3");
        rd(1'b0, 16'h0055, "wrap_4");
        rd(1'b1, 16'h0000, "wrap_empty");

        // Async reset with three entries and a press mid-debounce
        press(8'h61);
        press(8'h62);
        press(8'h63);
        rd(1'b1, 16'h0031, "pre_reset_status");
        switches = 8'h64;
        idle(3);
        enter_key = 1'b1;
        idle(4);
        #2;
        reset_n = 1'b0;
        #1;
        rd(1'b1, 16'h0000, "reset_status");
        enter_key = 1'b0;
        rd(1'b0, 16'h0000, "reset_data");
        reset_n = 1'b1;
        idle(15);
        rd(1'b1, 16'h0000, "post_reset_status");
        rd(1'b0, 16'h0000, "post_reset_data");

        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
